// File: rtl/crypto_dispatch_ctrl_pkg.sv
// Shared opcode encodings and FSM state types for the crypto dispatch controller.
package crypto_ctrl_pkg;

   localparam logic [1:0] OP_AES_ENC = 2'b00;
   localparam logic [1:0] OP_AES_DEC = 2'b01;
   localparam logic [1:0] OP_SHA     = 2'b10;
   localparam logic [1:0] OP_RSVD    = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2
   } core_state_t;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_AES  = 2'd1,
      ARB_SHA  = 2'd2
   } arb_state_t;

   typedef enum logic {
      LAST_AES = 1'b0,
      LAST_SHA = 1'b1
   } last_gnt_t;

endpackage

// File: rtl/crypto_dispatch_ctrl_if.sv
// Bundle of queue, core-control and shared-bus signals around the dispatcher.
// master = the dispatcher itself, slave = queue/cores/bus side.
interface crypto_dispatch_if #(
   parameter int ADDRW   = 8,
   parameter int OPCODEW = 2
) ();

   logic               q_valid;
   logic [OPCODEW-1:0] q_opcode;
   logic [ADDRW-1:0]   q_key_addr;
   logic [ADDRW-1:0]   q_text_addr;
   logic               q_ready;

   logic               aes_start;
   logic               aes_decrypt;
   logic [ADDRW-1:0]   aes_key_addr;
   logic [ADDRW-1:0]   aes_text_addr;
   logic               aes_done;

   logic               sha_start;
   logic [ADDRW-1:0]   sha_text_addr;
   logic               sha_done;

   logic               aes_bus_req;
   logic               sha_bus_req;
   logic               aes_bus_gnt;
   logic               sha_bus_gnt;

   logic               aes_busy;
   logic               sha_busy;
   logic               err_opcode;

   modport master (
      input  q_valid, q_opcode, q_key_addr, q_text_addr,
      input  aes_done, sha_done, aes_bus_req, sha_bus_req,
      output q_ready,
      output aes_start, aes_decrypt, aes_key_addr, aes_text_addr,
      output sha_start, sha_text_addr,
      output aes_bus_gnt, sha_bus_gnt,
      output aes_busy, sha_busy, err_opcode
   );

   modport slave (
      output q_valid, q_opcode, q_key_addr, q_text_addr,
      output aes_done, sha_done, aes_bus_req, sha_bus_req,
      input  q_ready,
      input  aes_start, aes_decrypt, aes_key_addr, aes_text_addr,
      input  sha_start, sha_text_addr,
      input  aes_bus_gnt, sha_bus_gnt,
      input  aes_busy, sha_busy, err_opcode
   );

endinterface

// File: rtl/crypto_dispatch_ctrl_bus_rr_arbiter.sv
// Two-requester round-robin arbiter for the shared memory-bus port.
// A grant is held until its request drops, followed by one idle turnaround cycle.
module bus_rr_arbiter
   import crypto_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic aes_req,
   input  logic sha_req,
   output logic aes_gnt,
   output logic sha_gnt
);

   arb_state_t state;
   last_gnt_t  last_gnt;

   // Arbiter FSM with registered grants; ties go to whoever did not win last.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ARB_IDLE;
         last_gnt <= LAST_SHA;
         aes_gnt  <= 1'b0;
         sha_gnt  <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (aes_req && (!sha_req || last_gnt == LAST_SHA)) begin
                  state    <= ARB_AES;
                  aes_gnt  <= 1'b1;
                  last_gnt <= LAST_AES;
               end else if (sha_req) begin
                  state    <= ARB_SHA;
                  sha_gnt  <= 1'b1;
                  last_gnt <= LAST_SHA;
               end
            end
            ARB_AES: begin
               if (!aes_req) begin
                  state   <= ARB_IDLE;
                  aes_gnt <= 1'b0;
               end
            end
            ARB_SHA: begin
               if (!sha_req) begin
                  state   <= ARB_IDLE;
                  sha_gnt <= 1'b0;
               end
            end
            default: begin
               state   <= ARB_IDLE;
               aes_gnt <= 1'b0;
               sha_gnt <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/crypto_dispatch_ctrl.sv
// In-order dispatcher from the request queue to the AES and SHA cores,
// with per-core start/busy tracking and the shared-bus arbiter.
module crypto_dispatch_ctrl
   import crypto_ctrl_pkg::*;
#(
   parameter int ADDRW   = 8,
   parameter int OPCODEW = 2
) (
   input logic                clk,
   input logic                rst_n,
   crypto_dispatch_if.master  bus
);

   logic             is_aes;
   logic             is_sha;
   logic             is_rsvd;
   logic             target_idle;
   logic             q_ready_int;
   logic             pop_aes;
   logic             pop_sha;
   logic             pop_rsvd;

   core_state_t      aes_state;
   logic             aes_start_r;
   logic             aes_busy_r;
   logic             aes_decrypt_r;
   logic [ADDRW-1:0] aes_key_r;
   logic [ADDRW-1:0] aes_text_r;

   core_state_t      sha_state;
   logic             sha_start_r;
   logic             sha_busy_r;
   logic [ADDRW-1:0] sha_text_r;

   logic             err_r;

   // Decode the head opcode and decide whether it may be popped this cycle.
   always_comb begin
      is_aes      = (bus.q_opcode == OPCODEW'(OP_AES_ENC)) ||
                    (bus.q_opcode == OPCODEW'(OP_AES_DEC));
      is_sha      = (bus.q_opcode == OPCODEW'(OP_SHA));
      is_rsvd     = (bus.q_opcode == OPCODEW'(OP_RSVD));
      target_idle = 1'b1;
      if (is_aes) begin
         target_idle = !aes_busy_r;
      end else if (is_sha) begin
         target_idle = !sha_busy_r;
      end
      q_ready_int = bus.q_valid && rst_n && target_idle;
      pop_aes     = q_ready_int && is_aes;
      pop_sha     = q_ready_int && is_sha;
      pop_rsvd    = q_ready_int && is_rsvd;
   end

   // AES job FSM: latch the job on pop, pulse start once, clear busy on done.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         aes_state     <= IDLE;
         aes_start_r   <= 1'b0;
         aes_busy_r    <= 1'b0;
         aes_decrypt_r <= 1'b0;
         aes_key_r     <= '0;
         aes_text_r    <= '0;
      end else begin
         aes_start_r <= 1'b0;
         case (aes_state)
            IDLE: begin
               if (pop_aes) begin
                  aes_state     <= START;
                  aes_start_r   <= 1'b1;
                  aes_busy_r    <= 1'b1;
                  aes_decrypt_r <= (bus.q_opcode == OPCODEW'(OP_AES_DEC));
                  aes_key_r     <= bus.q_key_addr;
                  aes_text_r    <= bus.q_text_addr;
               end
            end
            START: begin
               if (bus.aes_done) begin
                  aes_state  <= IDLE;
                  aes_busy_r <= 1'b0;
               end else begin
                  aes_state <= BUSY;
               end
            end
            BUSY: begin
               if (bus.aes_done) begin
                  aes_state  <= IDLE;
                  aes_busy_r <= 1'b0;
               end
            end
            default: begin
               aes_state  <= IDLE;
               aes_busy_r <= 1'b0;
            end
         endcase
      end
   end

   // SHA job FSM: same life cycle as AES, only a message address is latched.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sha_state   <= IDLE;
         sha_start_r <= 1'b0;
         sha_busy_r  <= 1'b0;
         sha_text_r  <= '0;
      end else begin
         sha_start_r <= 1'b0;
         case (sha_state)
            IDLE: begin
               if (pop_sha) begin
                  sha_state   <= START;
                  sha_start_r <= 1'b1;
                  sha_busy_r  <= 1'b1;
                  sha_text_r  <= bus.q_text_addr;
               end
            end
            START: begin
               if (bus.sha_done) begin
                  sha_state  <= IDLE;
                  sha_busy_r <= 1'b0;
               end else begin
                  sha_state <= BUSY;
               end
            end
            BUSY: begin
               if (bus.sha_done) begin
                  sha_state  <= IDLE;
                  sha_busy_r <= 1'b0;
               end
            end
            default: begin
               sha_state  <= IDLE;
               sha_busy_r <= 1'b0;
            end
         endcase
      end
   end

   // Reserved opcodes are consumed and flagged for one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else begin
         err_r <= pop_rsvd;
      end
   end

   bus_rr_arbiter u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .aes_req (bus.aes_bus_req),
      .sha_req (bus.sha_bus_req),
      .aes_gnt (bus.aes_bus_gnt),
      .sha_gnt (bus.sha_bus_gnt)
   );

   assign bus.q_ready       = q_ready_int;
   assign bus.aes_start     = aes_start_r;
   assign bus.aes_decrypt   = aes_decrypt_r;
   assign bus.aes_key_addr  = aes_key_r;
   assign bus.aes_text_addr = aes_text_r;
   assign bus.aes_busy      = aes_busy_r;
   assign bus.sha_start     = sha_start_r;
   assign bus.sha_text_addr = sha_text_r;
   assign bus.sha_busy      = sha_busy_r;
   assign bus.err_opcode    = err_r;

endmodule
